moonbase_io_bridge: RTL and testbench

Downstream companion to the 8-bit CPU's external bus. Decodes the CPU's multiplexed 8-bit output bus (address strobe, write strobes, nibble data), keeps the 7-bit device address latch, and assembles nibble-pair writes into bytes for a small device register map. It also returns 2-bit device read data to the CPU's device-input pins and drives an 8N1 serial transmitter fed by a small FIFO.

---
 rtl/moonbase_io_pkg.sv | 19 +
 rtl/moonbase_uart_tx.sv | 145 ++++++++++++++
 rtl/moonbase_io_bridge.sv | 104 ++++++++++
 tb/tb_moonbase_io_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moonbase_io_pkg.sv
// Shared definitions for the moonbase I/O bridge: device register map and
// the serial transmitter state encoding.
package moonbase_io_pkg;

  localparam logic [6:0] ADDR_GPIO0  = 7'd0;
  localparam logic [6:0] ADDR_GPIO1  = 7'd1;
  localparam logic [6:0] ADDR_TXDATA = 7'd2;
  localparam logic [6:0] ADDR_CTRL   = 7'd3;
  localparam logic [6:0] ADDR_FSTAT  = 7'd4;
  localparam logic [6:0] ADDR_TSTAT  = 7'd5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/moonbase_uart_tx.sv
// TX FIFO plus 8N1 serializer. Frames are emitted back to back while the
// FIFO holds data; the line idles high otherwise.
//
// Handshake: push is a one-cycle strobe with no ready. The byte is stored
// when the FIFO has room or a pop happens on the same edge; otherwise
// push_drop is asserted in that same cycle and the byte is discarded.
module moonbase_uart_tx
  import moonbase_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       push_drop,
  output tx_state_e  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          pop, push_ok, baud_end;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && !push_ok;
  assign baud_end  = (baud_q == BAUD_LAST);
  assign busy      = (state_q != TX_IDLE);
  assign tx        = tx_q;
  assign state_dbg = state_q;

  // FIFO storage; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // FIFO pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Serializer state register; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: start bit, 8 data bits LSB first, stop bit, then
  // either chain into the next frame or fall back to idle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr[AW-1:0]];
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr[AW-1:0]];
            tx_d    = 1'b0;
            bit_d   = '0;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/moonbase_io_bridge.sv
// CPU external-bus bridge: address latch, nibble-pair write assembly,
// GPIO registers, 2-bit device read-back and the serial transmitter.
module moonbase_io_bridge
  import moonbase_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  cpu_bus,
  output logic [1:0]  dev_data,
  output logic [6:0]  latch_addr,
  output logic [15:0] gpio_out,
  input  logic [7:0]  gpio_in,
  output logic        tx
);

  logic       wr_cycle, commit, tx_push, push_drop;
  logic       wr_half, overflow;
  logic [3:0] hi_q;
  logic [7:0] wr_byte;
  logic       fifo_full, fifo_empty, tx_busy;
  tx_state_e  unused_tx_state;
  logic       unused_bus_bits;

  // data_pc and the RAM write strobe belong to other bus agents.
  assign unused_bus_bits = ^cpu_bus[6:5];

  assign wr_cycle = !cpu_bus[7] && !cpu_bus[4];
  assign commit   = wr_cycle && wr_half;
  assign wr_byte  = {hi_q, cpu_bus[3:0]};
  assign tx_push  = commit && (latch_addr == ADDR_TXDATA);

  // Address latch and high-nibble capture; any non-write cycle drops a
  // half-assembled byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_addr <= '0;
      hi_q       <= '0;
      wr_half    <= 1'b0;
    end else begin
      if (cpu_bus[7]) latch_addr <= cpu_bus[6:0];
      if (wr_cycle && !wr_half) begin
        hi_q    <= cpu_bus[3:0];
        wr_half <= 1'b1;
      end else begin
        wr_half <= 1'b0;
      end
    end
  end

  // Committed bytes land in the GPIO registers by address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out <= '0;
    end else if (commit) begin
      if (latch_addr == ADDR_GPIO0) gpio_out[7:0]  <= wr_byte;
      if (latch_addr == ADDR_GPIO1) gpio_out[15:8] <= wr_byte;
    end
  end

  // Sticky overflow flag: set by a dropped push, cleared by a control write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (commit && (latch_addr == ADDR_CTRL)) begin
      overflow <= 1'b0;
    end
  end

  // Device read mux, purely combinational from the latched address.
  always_comb begin
    dev_data = 2'b00;
    case (latch_addr)
      7'd0:        dev_data = gpio_in[1:0];
      7'd1:        dev_data = gpio_in[3:2];
      7'd2:        dev_data = gpio_in[5:4];
      7'd3:        dev_data = gpio_in[7:6];
      ADDR_FSTAT:  dev_data = {fifo_full, fifo_empty};
      ADDR_TSTAT:  dev_data = {tx_busy, overflow};
      default:     dev_data = 2'b00;
    endcase
  end

  moonbase_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_push),
    .push_data (wr_byte),
    .tx        (tx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .busy      (tx_busy),
    .push_drop (push_drop),
    .state_dbg (unused_tx_state)
  );

endmodule

// File: tb/tb_moonbase_io_bridge.sv
// Bench for moonbase_io_bridge: bus-level stimulus, a transaction-level
// reference model, and a serial-line monitor fed from an expected queue.
module tb_moonbase_io_bridge;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [7:0] BUS_IDLE = 8'h30;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  cpu_bus;
  logic [7:0]  gpio_in;
  logic [1:0]  dev_data;
  logic [6:0]  latch_addr;
  logic [15:0] gpio_out;
  logic        tx;

  always #5 clk = ~clk;

  moonbase_io_bridge #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_bus    (cpu_bus),
    .dev_data   (dev_data),
    .latch_addr (latch_addr),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in),
    .tx         (tx)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transmitter modelled by timestamps: a byte leaves the FIFO at the first
  // edge where the line is free, and each frame holds the line 10*C edges.
  logic [6:0]  m_addr;
  logic [3:0]  m_hi;
  bit          m_half;
  logic [15:0] m_gpio;
  bit          m_ovf;
  logic [7:0]  m_byte;
  logic [7:0]  m_fifo[$];
  int          edge_n = 0;
  int          next_pop = 0;
  logic [7:0]  exp_q[$];
  int          exp_t[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_addr = '0; m_hi = '0; m_half = 0; m_gpio = '0; m_ovf = 0;
      m_fifo.delete(); exp_q.delete(); exp_t.delete();
      next_pop = 0;
    end else begin
      edge_n++;
      if (m_fifo.size() > 0 && edge_n >= next_pop) begin
        exp_q.push_back(m_fifo.pop_front());
        exp_t.push_back(edge_n);
        next_pop = edge_n + 10 * C;
      end
      if (cpu_bus[7]) begin
        m_addr = cpu_bus[6:0];
        m_half = 0;
      end else if (!cpu_bus[4]) begin
        if (m_half) begin
          m_byte = {m_hi, cpu_bus[3:0]};
          case (m_addr)
            7'd0: m_gpio[7:0]  = m_byte;
            7'd1: m_gpio[15:8] = m_byte;
            7'd2: if (m_fifo.size() < D) m_fifo.push_back(m_byte); else m_ovf = 1;
            7'd3: m_ovf = 0;
            default: ;
          endcase
          m_half = 0;
        end else begin
          m_hi = cpu_bus[3:0];
          m_half = 1;
        end
      end else begin
        m_half = 0;
      end
    end
  end

  function automatic logic [1:0] model_dev_data();
    int a;
    a = int'(m_addr);
    if (a <= 3)      return gpio_in[2*a +: 2];
    else if (a == 4) return {m_fifo.size() == D, m_fifo.size() == 0};
    else if (a == 5) return {edge_n < next_pop, m_ovf};
    else             return 2'b00;
  endfunction

  task automatic check_outs();
    chk("dev_data", 32'(dev_data), 32'(model_dev_data()));
    chk("latch_addr", 32'(latch_addr), 32'(m_addr));
    chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
  endtask

  // ---------------- serial monitor / scoreboard ----------------
  bit         mon_active = 0;
  int         mon_cnt;
  logic [7:0] mon_byte, mon_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
        mon_byte = '0;
        if (exp_t.size() == 0) begin
          checks++;
          errors++;
          mon_exp = '0;
          $display("FAIL tx_start: frame began at edge %0d, expected idle line", edge_n);
        end else begin
          chk("tx_start_edge", 32'(edge_n), 32'(exp_t.pop_front()));
          mon_exp = exp_q.pop_front();
        end
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == C / 2) begin
        int k;
        k = mon_cnt / C;
        if (k == 0) chk("tx_start_bit", 32'(tx), 32'd0);
        else if (k <= 8) mon_byte[k-1] = tx;
        else begin
          chk("tx_stop_bit", 32'(tx), 32'd1);
          chk("tx_byte", 32'(mon_byte), 32'(mon_exp));
        end
      end
      if (mon_cnt == 10 * C - 1) mon_active = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [7:0] v);
    @(negedge clk);
    check_outs();
    cpu_bus = v;
  endtask

  task automatic strobe(input logic [6:0] a);
    cyc({1'b1, a});
  endtask

  task automatic wr_nib(input logic [3:0] n);
    cyc({4'b0010, n});
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_nib(b[7:4]);
    wr_nib(b[3:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(BUS_IDLE);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_fifo.size() != 0 || exp_t.size() != 0 || mon_active) && n < 2000) begin
      cyc(BUS_IDLE);
      n++;
    end
    chk("drain_in_time", 32'(n < 2000), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    cpu_bus = BUS_IDLE;
    gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_gpio", 32'(gpio_out), 32'd0);
    check_outs();
    reset_n = 1'b1;

    // GPIO read-back
    gpio_in = 8'hC0;
    strobe(7'h03);
    cyc(BUS_IDLE);
    chk("gpio_read_a3", 32'(dev_data), 32'h3);

    // GPIO high byte write
    strobe(7'h01);
    wr_byte(8'hA5);
    cyc(BUS_IDLE);
    chk("gpio_hi_write", 32'(gpio_out), 32'hA500);

    // Lone nibble is discarded
    strobe(7'h00);
    wr_nib(4'h7);
    cyc(BUS_IDLE);
    wr_byte(8'h12);
    cyc(BUS_IDLE);
    chk("lone_nibble", 32'(gpio_out), 32'hA512);

    // Single serial frame, busy visible mid-frame
    strobe(7'h02);
    wr_byte(8'h55);
    strobe(7'h05);
    idle(8);
    chk("busy_mid_frame", 32'(dev_data[1]), 32'd1);
    drain();

    // Overflow: six pushes while the first frame is in flight
    strobe(7'h02);
    for (int i = 0; i < 6; i++) wr_byte(8'($urandom));
    strobe(7'h04);
    cyc(BUS_IDLE);
    chk("fifo_full", 32'(dev_data), 32'h2);
    strobe(7'h05);
    cyc(BUS_IDLE);
    chk("overflow_set", 32'(dev_data[0]), 32'd1);
    strobe(7'h03);
    wr_byte(8'h00);
    strobe(7'h05);
    cyc(BUS_IDLE);
    chk("overflow_clear", 32'(dev_data[0]), 32'd0);
    drain();

    // Randomized bus traffic
    repeat (120) begin
      case ($urandom_range(0, 4))
        0: begin
          int a;
          a = int'($urandom_range(0, 7));
          strobe(a == 7 ? 7'($urandom_range(6, 127)) : 7'(a));
        end
        1: wr_byte(8'($urandom));
        2: begin
          wr_nib(4'($urandom));
          cyc(BUS_IDLE);
        end
        3: begin
          gpio_in = 8'($urandom);
          cyc(BUS_IDLE);
        end
        default: cyc({1'b0, 2'($urandom), 1'b1, 4'($urandom)});
      endcase
    end
    drain();

    // Reset during the data bits of a frame
    strobe(7'h02);
    wr_byte(8'hC3);
    idle(3 * C);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("reset_async_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    chk("reset_gpio_mid", 32'(gpio_out), 32'd0);
    reset_n = 1'b1;
    strobe(7'h04);
    cyc(BUS_IDLE);
    chk("reset_fifo_empty", 32'(dev_data), 32'h1);
    strobe(7'h05);
    cyc(BUS_IDLE);
    chk("reset_tx_idle", 32'(dev_data), 32'h0);
    idle(12 * C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
